// File: rtl/adc_capture_if.sv
// FIFO write-side bundle: adc_capture drives it as master, the measurement FIFO is the slave.
interface adc_capture_if #(
  parameter int DATA_W = 24
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;

  modport master (output wr_en, output wr_data, input fifo_full);
  modport slave  (input wr_en, input wr_data, output fifo_full);
endinterface

// File: rtl/adc_capture.sv
// ADC acquisition front end: discards pipeline-latency samples, block-averages
// channels A and B and pushes each averaged {A,B} pair into the measurement FIFO.
module adc_capture #(
  parameter int ADC_WIDTH      = 12,
  parameter int MEAS_POINTS    = 4096,
  parameter int SETTLE_SAMPLES = 8,
  parameter int MAX_AVG_LOG2   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           avg_log2,
  input  logic                 sample_en,
  input  logic [ADC_WIDTH-1:0] adc_a,
  input  logic [ADC_WIDTH-1:0] adc_b,
  adc_capture_if.master        fifo,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [12:0]          word_cnt
);
  localparam int         ACC_W   = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int         BLK_W   = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam int         SET_W   = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [2:0] AVG_MAX = 3'(MAX_AVG_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACQ, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             avg_q, avg_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [BLK_W-1:0]       blk_q, blk_d;
  logic [ACC_W-1:0]       acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic                   samp_vld_q, samp_vld_d;
  logic [ADC_WIDTH-1:0]   samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [2*ADC_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   overrun_q, overrun_d;
  logic [12:0]            word_cnt_q, word_cnt_d;

  logic [ACC_W-1:0] sum_a, sum_b;
  logic [BLK_W-1:0] blk_mask;
  logic             blk_last, wr_fire, wr_drop, settle_last;

  always_comb begin
    sum_a       = acc_a_q + ACC_W'(samp_a_q);
    sum_b       = acc_b_q + ACC_W'(samp_b_q);
    blk_mask    = BLK_W'((32'd1 << avg_q) - 32'd1);
    blk_last    = samp_vld_q && (blk_q == blk_mask);
    // A pending word leaves only if the FIFO has room and the run is not being cancelled.
    wr_fire     = wr_pend_q && !fifo.fifo_full && !abort;
    wr_drop     = wr_pend_q &&  fifo.fifo_full && !abort;
    settle_last = (32'(settle_q) == SETTLE_SAMPLES - 1);

    // NOTE: every _d gets a default first so no branch can leave it unassigned and infer a latch.
    state_d    = state_q;
    avg_d      = avg_q;
    settle_d   = settle_q;
    blk_d      = blk_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    samp_vld_d = 1'b0;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    wr_pend_d  = 1'b0;
    wr_data_d  = wr_data_q;
    overrun_d  = overrun_q;
    word_cnt_d = word_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          avg_d      = (avg_log2 > AVG_MAX) ? AVG_MAX : avg_log2;
          settle_d   = '0;
          blk_d      = '0;
          acc_a_d    = '0;
          acc_b_d    = '0;
          word_cnt_d = '0;
          overrun_d  = 1'b0;
          state_d    = (SETTLE_SAMPLES == 0) ? S_ACQ : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sample_en) begin
          settle_d = settle_q + SET_W'(1);
          if (settle_last) state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        samp_vld_d = sample_en;
        if (sample_en) begin
          samp_a_d = adc_a;
          samp_b_d = adc_b;
        end
        // The closing sample restarts the block from zero, so a strobe landing now is kept.
        if (blk_last) begin
          blk_d     = '0;
          acc_a_d   = '0;
          acc_b_d   = '0;
          wr_pend_d = 1'b1;
          wr_data_d = {ADC_WIDTH'(sum_a >> avg_q), ADC_WIDTH'(sum_b >> avg_q)};
        end else if (samp_vld_q) begin
          blk_d   = blk_q + BLK_W'(1);
          acc_a_d = sum_a;
          acc_b_d = sum_b;
        end
        if (wr_fire) word_cnt_d = word_cnt_q + 13'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (wr_drop) begin
          overrun_d = 1'b1;
          state_d   = S_DONE;
        end else if (wr_fire && word_cnt_d == 13'(MEAS_POINTS)) begin
          state_d = S_DONE;
        end
        if (state_d != S_ACQ) begin
          wr_pend_d  = 1'b0;
          samp_vld_d = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment only; blocking belongs in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      avg_q      <= '0;
      settle_q   <= '0;
      blk_q      <= '0;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      samp_vld_q <= 1'b0;
      samp_a_q   <= '0;
      samp_b_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
      overrun_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      avg_q      <= avg_d;
      settle_q   <= settle_d;
      blk_q      <= blk_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      samp_vld_q <= samp_vld_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
      overrun_q  <= overrun_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign fifo.wr_en   = wr_fire;
  assign fifo.wr_data = wr_data_q;
  assign busy         = (state_q == S_SETTLE) || (state_q == S_ACQ);
  assign done         = (state_q == S_DONE);
  assign overrun      = overrun_q;
  assign word_cnt     = word_cnt_q;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: per-scenario stimulus tables, expectations derived from
// block/run rules over the whole table, checked cycle by cycle.
module tb_adc_capture;
  localparam int ADC_W    = 12;
  localparam int MEAS     = 4;
  localparam int SETTLE   = 2;
  localparam int MAX_LOG2 = 4;
  localparam int NMAX     = 160;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              sample_en = 1'b0;
  logic [2:0]        avg_log2 = '0;
  logic [ADC_W-1:0]  adc_a = '0;
  logic [ADC_W-1:0]  adc_b = '0;
  logic              busy, done, overrun;
  logic [12:0]       word_cnt;

  adc_capture_if #(.DATA_W(2*ADC_W)) fifo ();

  adc_capture #(
    .ADC_WIDTH(ADC_W), .MEAS_POINTS(MEAS), .SETTLE_SAMPLES(SETTLE), .MAX_AVG_LOG2(MAX_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .avg_log2(avg_log2),
    .sample_en(sample_en), .adc_a(adc_a), .adc_b(adc_b), .fifo(fifo),
    .busy(busy), .done(done), .overrun(overrun), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus table for one scenario; the run's start is always at cycle 0.
  logic             st_start[NMAX], st_abort[NMAX], st_sen[NMAX], st_full[NMAX];
  logic [ADC_W-1:0] st_a[NMAX], st_b[NMAX];
  logic [2:0]       st_avg;

  bit               ex_wr[NMAX], ex_busy[NMAX], ex_done[NMAX], ex_ovr[NMAX];
  logic [2*ADC_W-1:0] ex_data[NMAX];
  int               ex_wc[NMAX];
  int               prev_wc = 0;
  bit               prev_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NMAX; c++) begin
      st_start[c] = 1'b0; st_abort[c] = 1'b0; st_sen[c] = 1'b0; st_full[c] = 1'b0;
      st_a[c] = '0; st_b[c] = '0;
    end
    st_avg = '0;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; sample_en = 1'b0; avg_log2 = '0;
    adc_a = '0; adc_b = '0; fifo.fifo_full = 1'b0;
  endtask

  // Expected behaviour of a run from its stimulus table: drop the first SETTLE strobes,
  // average consecutive groups of 2^n accepted samples, write two cycles after each
  // group's last strobe, and end on MEAS words, a full FIFO, or abort.
  task automatic build_expect(input int n);
    int lg, len, abort_c, acq_start, seen, end_busy, done_c, drop_c, nwr, w, sa, sb;
    bit run, ended;
    int qc[$];
    lg  = (int'(st_avg) > MAX_LOG2) ? MAX_LOG2 : int'(st_avg);
    len = 1 << lg;
    run = st_start[0] && !st_abort[0];
    abort_c = n;
    for (int c = 1; c < n; c++) if (st_abort[c]) begin abort_c = c; break; end
    acq_start = n;
    if (SETTLE == 0) acq_start = 1;
    else begin
      seen = 0;
      for (int c = 1; c < n; c++)
        if (st_sen[c]) begin
          seen++;
          if (seen == SETTLE) begin acq_start = c + 1; break; end
        end
    end
    for (int c = acq_start; c < n; c++) if (st_sen[c]) qc.push_back(c);
    for (int c = 0; c < NMAX; c++) begin
      ex_wr[c] = 1'b0; ex_data[c] = '0; ex_busy[c] = 1'b0; ex_done[c] = 1'b0;
    end
    end_busy = 0; done_c = -1; drop_c = -1; nwr = 0; ended = 1'b0;
    if (run) begin
      for (int j = 0; j + len <= qc.size() && !ended; j += len) begin
        w = qc[j+len-1] + 2;
        if (w >= abort_c) break;
        sa = 0; sb = 0;
        for (int k = 0; k < len; k++) begin
          sa += int'(st_a[qc[j+k]]);
          sb += int'(st_b[qc[j+k]]);
        end
        if (st_full[w]) begin
          drop_c = w; end_busy = w; done_c = w + 1; ended = 1'b1;
        end else begin
          ex_wr[w] = 1'b1;
          ex_data[w] = {ADC_W'(sa >> lg), ADC_W'(sb >> lg)};
          nwr++;
          if (nwr == MEAS) begin end_busy = w; done_c = w + 1; ended = 1'b1; end
        end
      end
      if (!ended) end_busy = (abort_c < n) ? abort_c : n - 1;
    end
    for (int c = 0; c < n; c++) begin
      ex_busy[c] = run && c > 0 && c <= end_busy;
      ex_done[c] = (c == done_c);
      if (run && c > 0) begin
        ex_wc[c] = 0;
        for (int d = 0; d < c; d++) if (ex_wr[d]) ex_wc[c]++;
        ex_ovr[c] = (drop_c >= 0) && (c > drop_c);
      end else begin
        ex_wc[c] = prev_wc;
        ex_ovr[c] = prev_ovr;
      end
    end
    if (run) begin
      prev_wc  = nwr;
      prev_ovr = (drop_c >= 0);
    end
  endtask

  task automatic run_cycles(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      start = st_start[c]; abort = st_abort[c]; sample_en = st_sen[c]; avg_log2 = st_avg;
      adc_a = st_a[c]; adc_b = st_b[c]; fifo.fifo_full = st_full[c];
      @(negedge clk);
      check($sformatf("%s c%0d wr_en", name, c), 32'(fifo.wr_en), 32'(ex_wr[c]));
      if (ex_wr[c]) check($sformatf("%s c%0d wr_data", name, c), 32'(fifo.wr_data), 32'(ex_data[c]));
      check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(ex_busy[c]));
      check($sformatf("%s c%0d done", name, c), 32'(done), 32'(ex_done[c]));
      check($sformatf("%s c%0d overrun", name, c), 32'(overrun), 32'(ex_ovr[c]));
      check($sformatf("%s c%0d word_cnt", name, c), 32'(word_cnt), 32'(ex_wc[c]));
    end
  endtask

  task automatic load_normal();
    clear_stim();
    st_start[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      st_sen[i] = 1'b1; st_a[i] = ADC_W'(i); st_b[i] = ADC_W'(99 + i);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " wr_en"},    32'(fifo.wr_en),   32'd0);
    check({name, " wr_data"},  32'(fifo.wr_data), 32'd0);
    check({name, " busy"},     32'(busy),         32'd0);
    check({name, " done"},     32'(done),         32'd0);
    check({name, " overrun"},  32'(overrun),      32'd0);
    check({name, " word_cnt"}, 32'(word_cnt),     32'd0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Normal run, plus a start pulse in ACQ that must be ignored.
    load_normal();
    st_start[4] = 1'b1;
    st_abort[11] = 1'b1;
    build_expect(12);
    run_cycles("normal", 12);

    // Averaging by 4 with truncation: {5,4095} then {1,0}.
    clear_stim();
    st_start[0] = 1'b1; st_avg = 3'd2;
    for (int i = 1; i <= 10; i++) st_sen[i] = 1'b1;
    st_a[3] = 12'd4; st_a[4] = 12'd5; st_a[5] = 12'd6; st_a[6] = 12'd7;
    for (int i = 3; i <= 6; i++) st_b[i] = 12'd4095;
    st_a[7] = 12'd1; st_a[8] = 12'd1; st_a[9] = 12'd1; st_a[10] = 12'd2;
    st_abort[15] = 1'b1;
    build_expect(16);
    run_cycles("average", 16);

    // Exponent 7 clamps to 16 samples per word.
    clear_stim();
    st_start[0] = 1'b1; st_avg = 3'd7;
    for (int i = 1; i <= 66; i++) begin
      st_sen[i] = 1'b1; st_a[i] = ADC_W'($urandom); st_b[i] = ADC_W'($urandom);
    end
    st_abort[74] = 1'b1;
    build_expect(75);
    run_cycles("clamp", 75);

    // FIFO full on the second write drops it and ends the run with overrun.
    load_normal();
    st_full[6] = 1'b1;
    st_abort[9] = 1'b1;
    build_expect(10);
    run_cycles("full", 10);

    // Abort after two of four block samples; this start also clears overrun.
    clear_stim();
    st_start[0] = 1'b1; st_avg = 3'd2;
    for (int i = 1; i <= 4; i++) begin st_sen[i] = 1'b1; st_a[i] = ADC_W'(i * 7); end
    st_abort[5] = 1'b1;
    st_abort[7] = 1'b1;
    build_expect(8);
    run_cycles("abort", 8);

    // Fresh start after the abort gives a complete block.
    clear_stim();
    st_start[0] = 1'b1; st_avg = 3'd2;
    for (int i = 1; i <= 6; i++) st_sen[i] = 1'b1;
    st_a[3] = 12'd10; st_a[4] = 12'd20; st_a[5] = 12'd30; st_a[6] = 12'd41;
    st_b[3] = 12'd4095; st_b[4] = 12'd0; st_b[5] = 12'd1; st_b[6] = 12'd2;
    st_abort[11] = 1'b1;
    build_expect(12);
    run_cycles("restart", 12);

    // Start and abort in the same idle cycle: abort wins.
    clear_stim();
    st_start[0] = 1'b1; st_abort[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin st_sen[i] = 1'b1; st_a[i] = ADC_W'($urandom); end
    build_expect(6);
    run_cycles("start_abort", 6);

    // Randomized runs: sparse strobes, random data, exponents, FIFO stalls and aborts.
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      st_start[0] = 1'b1;
      st_avg = 3'($urandom_range(0, 5));
      for (int c = 0; c < 100; c++) begin
        st_sen[c]   = ($urandom_range(0, 3) != 0);
        st_a[c]     = ADC_W'($urandom);
        st_b[c]     = ADC_W'($urandom);
        st_full[c]  = ($urandom_range(0, 15) == 0);
        st_abort[c] = (c > 0) && ($urandom_range(0, 119) == 0);
      end
      st_abort[99] = 1'b1;
      build_expect(100);
      run_cycles($sformatf("random%0d", r), 100);
    end

    // Reset asserted mid-run, right after a write cycle.
    load_normal();
    st_abort[11] = 1'b1;
    build_expect(12);
    run_cycles("pre_reset", 7);
    #1 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    idle_inputs();
    prev_wc  = 0;
    prev_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_normal();
    st_abort[11] = 1'b1;
    build_expect(12);
    run_cycles("post_reset", 12);

    idle_inputs();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
